twiddle_addr_seq: RTL

//  Address sequencer for the 64-point FFT twiddle ROM (8x8 table, row-major order).
//  On a frame START it waits a programmable alignment delay, then issues ROM addresses 0..63,
//    one per enabled clock.

---
 rtl/twiddle_addr_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/twiddle_addr_seq.sv
// Address sequencer for the 64-point FFT twiddle ROM (8x8, row-major).
// After START and a DLY-cycle alignment delay it issues addresses 0..63, flagging w0 twiddles.
module twiddle_addr_seq #(
  parameter int unsigned DLY = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ED,
  input  logic       START,
  output logic [5:0] ADDR,
  output logic       TW_VLD,
  output logic       TRIV,
  output logic       BUSY,
  output logic       RDY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [3:0] LP_WLAST = (DLY > 0) ? 4'(DLY - 1) : 4'd0;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_wcnt;
  logic [3:0] w_wcnt_nxt;
  logic [5:0] r_addr;
  logic [5:0] w_addr_nxt;
  logic       r_vld;
  logic       w_vld_nxt;
  logic       r_triv;
  logic       r_busy;
  logic       r_rdy;
  logic       w_rdy_nxt;
  logic       w_triv_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_addr_nxt  = r_addr;
    w_vld_nxt   = r_vld;
    w_rdy_nxt   = 1'b0;

    unique case (r_state)
      S_WAIT: begin
        if (r_wcnt == LP_WLAST) begin
          w_state_nxt = S_RUN;
          w_addr_nxt  = '0;
          w_vld_nxt   = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt + 4'd1;
        end
      end
      S_RUN: begin
        if (&r_addr) begin
          w_state_nxt = S_IDLE;
          w_addr_nxt  = '0;
          w_vld_nxt   = 1'b0;
          w_rdy_nxt   = 1'b1;
        end else begin
          w_addr_nxt = r_addr + 6'd1;
        end
      end
      default: ;
    endcase

    // START overrides the frame progression but keeps any RDY earned on the 63 edge.
    if (START) begin
      w_addr_nxt = '0;
      w_wcnt_nxt = '0;
      if (DLY == 0) begin
        w_state_nxt = S_RUN;
        w_vld_nxt   = 1'b1;
      end else begin
        w_state_nxt = S_WAIT;
        w_vld_nxt   = 1'b0;
      end
    end
  end

  assign w_triv_nxt = w_vld_nxt && ((w_addr_nxt[5:3] == 3'd0) || (w_addr_nxt[2:0] == 3'd0));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_vld   <= 1'b0;
      r_triv  <= 1'b0;
      r_busy  <= 1'b0;
      r_rdy   <= 1'b0;
    end else if (ED) begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_addr  <= w_addr_nxt;
      r_vld   <= w_vld_nxt;
      r_triv  <= w_triv_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_rdy   <= w_rdy_nxt;
    end
  end

  assign ADDR   = r_addr;
  assign TW_VLD = r_vld;
  assign TRIV   = r_triv;
  assign BUSY   = r_busy;
  assign RDY    = r_rdy;

endmodule
